uart_rx: RTL
============

Name: uart_rx

Overview:
UART receive deframer that consumes the oversampling `tick` produced by the baud generator, which pulses 16× per bit period.
- Synchronizes the asynchronous serial input and detects the start bit.
- Samples data bits at bit centre, LSB first.
- Optionally checks parity and checks the stop bit.
- Presents each received byte through a one-entry valid/ready holding register to the downstream consumer, such as the RX FIFO or bus interface.

Parameters:
DBIT, 8, data bits per frame (5..8)
SB_TICK, 16, ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2; must be ≥ 16)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tick  in  1  16× oversample strobe from baud generator, one clk wide
rx  in  1  asynchronous serial line, idle high
parity_en  in  1  1 = a parity bit follows the data bits
parity_odd  in  1  1 = odd parity, 0 = even parity
rx_data  out  DBIT  received byte, valid while rx_valid = 1
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts; transfer happens when rx_valid & rx_ready
frame_err  out  1  sticky: stop bit sampled 0
parity_err  out  1  sticky: parity mismatch
overrun_err  out  1  sticky: frame completed while holding register still full
err_clr  in  1  one-cycle pulse clears all three sticky flags

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state = IDLE; tick counter s = 0; bit counter n = 0; shift register = 0; all outputs = 0.
- The rx line passes through a 2-flop synchronizer with reset value 1; rx_s lags rx by 2 clk. All decisions use rx_s.
- All state advances except IDLE→START are qualified by tick. Cycles without tick hold all state.
- IDLE: when rx_s == 0, go to START with s = 0. This transition does not require tick. parity_en and parity_odd are latched here and are static for the frame.
- START: on each tick, s++. When s == 7 (mid start bit):
  - if rx_s == 0, go to DATA with s = 0, n = 0;
  - otherwise it is a glitch: return to IDLE with no flags set.
- DATA: on each tick, s++. When s == 15, shift rx_s into the MSB (LSB-first right shift), set s = 0, and n++. When n == DBIT-1 at that point, go to PARITY if parity_en, else go to STOP.
- PARITY: when s == 15 on tick, sample the parity bit and set s = 0, then go to STOP.
  - Mismatch (even parity: XOR of data and parity bit ≠ 0; odd parity: ≠ 1) is recorded as a pending parity error.
- STOP: when s == SB_TICK-1 on tick, sample rx_s; rx_s == 0 → frame error. Then complete the frame and go to IDLE.
- Frame completion (same clk as the final stop tick; outputs update on the next edge):
  - if rx_valid == 0, or rx_valid & rx_ready in that same cycle: load rx_data and set rx_valid = 1;
  - otherwise keep old rx_data, set overrun_err, and discard the new byte.
  - frame_err and parity_err are set on completion when applicable. They are set even on an overrun, and the byte is still delivered when not overrun.
- rx_valid clears on the edge after rx_valid & rx_ready unless a load coincides, in which case it stays at 1 with new data. rx_data is stable while rx_valid = 1.
- Latency: rx_valid rises 1 clk after the tick that samples the stop bit.
- Sticky flags:
  - err_clr clears all three flags.
  - A set event in the same cycle as err_clr wins, so the flag stays 1.
- The stop state returns to IDLE at end of stop time. A low rx_s in IDLE immediately after a frame error (break) restarts start detection, so repeated false frames with frame_err are acceptable.
- reset_n assertion mid-frame aborts immediately. After release the partial frame is not delivered and the block waits in IDLE for a fresh falling edge; if rx is still low it re-detects a start.

Decomposition:
- Package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam OVERSAMPLE = 16;
  - localparam MID_START = 7.
- One sub-module: sync_2ff, a 2-flop synchronizer with a reset-value parameter, instantiated for rx.
- Shift register, counters, FSM and holding register stay in uart_rx.

Test Plan:
- Bench tick every 4 clk, parity_en = 0, send frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → rx_valid = 1 with rx_data = 0xA5, no flags, valid 1 clk after stop-sample tick.
- parity_en = 1, parity_odd = 0, send 0x03 with parity bit 1 → parity_err = 1, rx_data = 0x03 delivered; same frame with parity bit 0 → no parity_err.
- Send 0x55 with stop bit forced 0 → frame_err = 1, rx_valid = 1, rx_data = 0x55; pulse err_clr → frame_err = 0.
- rx low for 5 ticks then high (glitch) → returns to IDLE, rx_valid stays 0, no flags.
- rx_ready held 0, send 0x11 then 0x22 → rx_data stays 0x11, overrun_err = 1; raise rx_ready → rx_valid = 0.
- Assert reset_n = 0 during DATA bit 4 of 0xF0, release, send 0x0F → only 0x0F is delivered, with all flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t  : receiver deframer states
//   OVERSAMPLE  : ticks per bit period
//   MID_START   : tick index at which the start bit is re-checked
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Valid/ready byte hand-off from the UART receiver to its consumer.
//   rx_data  : received byte, stable while rx_valid = 1
//   rx_valid : holding register full
//   rx_ready : consumer accepts; transfer on rx_valid & rx_ready
// Modports:
//   master : the receiver (drives data/valid)
//   slave  : the consumer (drives ready)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int DBIT = 8
);

  logic [DBIT-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
//   clk       : destination clock
//   reset_n   : asynchronous active-low reset
//   d         : asynchronous input
//   q         : synchronized output, lags d by two clocks
// RESET_VAL sets the value both flops take in reset, so an idle-high line
// does not look like a falling edge right after reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Plain two-stage shift toward the clock domain; meta is never used
  // anywhere except as the input to q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receive deframer driven by a 16x oversample tick.
//   clk, reset_n : system clock, asynchronous active-low reset
//   tick         : 16x oversample strobe, one clk wide
//   rx           : asynchronous serial line, idle high
//   parity_en    : a parity bit follows the data bits
//   parity_odd   : 1 = odd parity, 0 = even parity
//   bus          : valid/ready byte output (uart_rx_if.master)
//   frame_err    : sticky, stop bit sampled low
//   parity_err   : sticky, parity mismatch
//   overrun_err  : sticky, frame finished while holding register full
//   err_clr      : one-cycle pulse clearing all sticky flags
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      tick,
  input  logic      rx,
  input  logic      parity_en,
  input  logic      parity_odd,
  uart_rx_if.master bus,
  output logic      frame_err,
  output logic      parity_err,
  output logic      overrun_err,
  input  logic      err_clr
);

  // Tick counter must reach SB_TICK-1, which is also at least OVERSAMPLE-1.
  localparam int SW = $clog2(SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  rx_state_t       state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] shreg;
  logic            par_en_l;
  logic            par_odd_l;
  logic            par_pend;
  logic            rx_s;

  logic stop_done;
  logic load;
  logic overrun;
  logic fe_set;
  logic pe_set;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // Frame completion happens on the tick that samples the stop bit. The new
  // byte is only accepted if the holding register is empty or being drained
  // in this very cycle; otherwise it is dropped and flagged as an overrun.
  assign stop_done = (state == STOP) && tick && (s == SW'(SB_TICK - 1));
  assign load      = stop_done && (!bus.rx_valid || bus.rx_ready);
  assign overrun   = stop_done && bus.rx_valid && !bus.rx_ready;
  assign fe_set    = stop_done && !rx_s;
  assign pe_set    = stop_done && par_pend;

  // Deframing state machine. Only the IDLE->START move reacts to the line
  // directly; every other step waits for a tick so the counters measure
  // time in oversample units. Parity settings are captured at the start of
  // a frame so a mid-frame change cannot corrupt the check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      shreg     <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      par_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state     <= START;
            s         <= '0;
            par_en_l  <= parity_en;
            par_odd_l <= parity_odd;
            par_pend  <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (s == SW'(MID_START)) begin
              s <= '0;
              if (!rx_s) begin
                state <= DATA;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == SW'(OVERSAMPLE - 1)) begin
              s     <= '0;
              n     <= n + NW'(1);
              shreg <= {rx_s, shreg[DBIT-1:1]};
              if (n == NW'(DBIT - 1)) begin
                state <= par_en_l ? PARITY : STOP;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (s == SW'(OVERSAMPLE - 1)) begin
              s        <= '0;
              // XOR of data and parity bit must equal par_odd_l.
              par_pend <= (^shreg) ^ rx_s ^ par_odd_l;
              state    <= STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s == SW'(SB_TICK - 1)) begin
              s     <= '0;
              state <= IDLE;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          s     <= '0;
        end
      endcase
    end
  end

  // Holding register and sticky error flags. A load in the same cycle as a
  // consumer transfer keeps rx_valid high with fresh data. Set events beat
  // err_clr so an error landing on the clear pulse is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      if (load) begin
        bus.rx_data  <= shreg;
        bus.rx_valid <= 1'b1;
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end

      if (fe_set) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end

      if (pe_set) begin
        parity_err <= 1'b1;
      end else if (err_clr) begin
        parity_err <= 1'b0;
      end

      if (overrun) begin
        overrun_err <= 1'b1;
      end else if (err_clr) begin
        overrun_err <= 1'b0;
      end
    end
  end

endmodule
